// File: rtl/ctrl_encode_def.sv
// Shared encodings for the multicycle MIPS control unit: ALU opcodes,
// FSM states, instruction opcode/funct fields and datapath mux selects.
package ctrl_encode_def;

    // ALU opcode driven onto alu_op
    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_NOR  = 4'd9,
        ALU_IMM  = 4'd10
    } alu_op_t;

    // Control FSM states, exported on state_o for debug
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWR  = 4'd5,
        S_MEMWB  = 4'd6,
        S_EXE    = 4'd7,
        S_ALUWB  = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    // IR[31:26] opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // IR[5:0] funct codes for R-type
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Datapath mux select codes
    localparam logic [1:0] SRCA_PC      = 2'd0;
    localparam logic [1:0] SRCA_RS      = 2'd1;
    localparam logic [1:0] SRCA_SHAMT   = 2'd2;
    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;
    localparam logic [1:0] DST_RT       = 2'd0;
    localparam logic [1:0] DST_RD       = 2'd1;
    localparam logic [1:0] DST_RA       = 2'd2;
    localparam logic [1:0] WD_ALUOUT    = 2'd0;
    localparam logic [1:0] WD_MDR       = 2'd1;
    localparam logic [1:0] WD_PC        = 2'd2;
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mc_alu_dec.sv
// ALU decoder: maps (state, op, funct) to the ALU opcode, the immediate
// extension mode, and a flag for R-type funct codes that cannot be decoded.
module mc_alu_dec
    import ctrl_encode_def::*;
#(
    parameter int OPW    = 6,
    parameter int ALUOPW = 4
) (
    input  state_t            i_state,
    input  logic [OPW-1:0]    i_op,
    input  logic [OPW-1:0]    i_funct,
    output logic [ALUOPW-1:0] o_alu_op,
    output logic              o_ext_sign,
    output logic              o_illegal_funct
);

    alu_op_t w_alu;

    // Per-state ALU operation and immediate extension
    // NOTE: every output gets a default before the case so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_alu           = ALU_NOP;
        o_ext_sign      = 1'b0;
        o_illegal_funct = 1'b0;
        case (i_state)
            S_FETCH: w_alu = ALU_ADD;                   // PC + 4
            S_DECODE, S_MEMADR: begin                   // branch target / address
                w_alu      = ALU_ADD;
                o_ext_sign = 1'b1;
            end
            S_EXE: begin
                case (i_funct)
                    FN_ADD:  w_alu = ALU_ADD;
                    FN_SUB:  w_alu = ALU_SUB;
                    FN_AND:  w_alu = ALU_AND;
                    FN_OR:   w_alu = ALU_OR;
                    FN_NOR:  w_alu = ALU_NOR;
                    FN_SLT:  w_alu = ALU_SLT;
                    FN_SLTU: w_alu = ALU_SLTU;
                    FN_SLL:  w_alu = ALU_SLL;
                    FN_SRL:  w_alu = ALU_SRL;
                    FN_JR:   w_alu = ALU_NOP;
                    default: o_illegal_funct = 1'b1;
                endcase
            end
            S_IMMEX: begin
                case (i_op)
                    OP_ADDI: begin w_alu = ALU_ADD; o_ext_sign = 1'b1; end
                    OP_SLTI: begin w_alu = ALU_SLT; o_ext_sign = 1'b1; end
                    OP_ANDI: w_alu = ALU_AND;
                    OP_ORI:  w_alu = ALU_OR;
                    OP_LUI:  w_alu = ALU_IMM;
                    default: w_alu = ALU_NOP;
                endcase
            end
            S_BRANCH: w_alu = ALU_SUB;                  // rs - rt sets Zero
            default:  w_alu = ALU_NOP;
        endcase
    end

    assign o_alu_op = ALUOPW'(w_alu);

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/
// writeback, handshakes with unified memory and drives datapath controls.
module mc_ctrl
    import ctrl_encode_def::*;
#(
    parameter int OPW    = 6,
    parameter int ALUOPW = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [OPW-1:0]    op,
    input  logic [OPW-1:0]    funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic              ir_write,
    output logic              pc_write,
    output logic              reg_write,
    output logic [1:0]        alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic              ext_sign,
    output logic [1:0]        reg_dst,
    output logic [1:0]        wd_sel,
    output logic [1:0]        pc_src,
    output logic [ALUOPW-1:0] alu_op,
    output logic              illegal,
    output logic [3:0]        state_o
);

    state_t r_state;
    state_t w_next;
    logic   w_illegal_funct;

    mc_alu_dec #(
        .OPW    (OPW),
        .ALUOPW (ALUOPW)
    ) u_alu_dec (
        .i_state         (r_state),
        .i_op            (op),
        .i_funct         (funct),
        .o_alu_op        (alu_op),
        .o_ext_sign      (ext_sign),
        .o_illegal_funct (w_illegal_funct)
    );

    // State register; reset drops straight to IDLE so all outputs clear at once
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state and datapath control decode
    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_RT;
        reg_dst   = DST_RT;
        wd_sel    = WD_ALUOUT;
        pc_src    = PCSRC_ALU;
        illegal   = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                case (op)
                    OP_LW, OP_SW:                           w_next = S_MEMADR;
                    OP_RTYPE:                               w_next = S_EXE;
                    OP_BEQ, OP_BNE:                         w_next = S_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: w_next = S_IMMEX;
                    OP_J, OP_JAL:                           w_next = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        w_next  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_IMM;
                w_next    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_MEMWB: begin
                reg_write = 1'b1;
                wd_sel    = WD_MDR;
                w_next    = S_FETCH;
            end
            S_EXE: begin
                if (w_illegal_funct) begin
                    illegal = 1'b1;
                    w_next  = S_FETCH;
                end else if (funct == FN_JR) begin
                    alu_src_a = SRCA_RS;
                    pc_write  = 1'b1;
                    w_next    = S_FETCH;
                end else begin
                    alu_src_a = (funct == FN_SLL || funct == FN_SRL) ? SRCA_SHAMT : SRCA_RS;
                    w_next    = S_ALUWB;
                end
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = DST_RD;
                w_next    = S_FETCH;
            end
            S_IMMEX: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_IMM;
                w_next    = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RS;
                pc_src    = PCSRC_ALUOUT;
                pc_write  = (op == OP_BEQ) ? zero : !zero;
                w_next    = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
                if (op == OP_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = DST_RA;
                    wd_sel    = WD_PC;
                end
                w_next = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign state_o = r_state;

endmodule
